// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter for the peripheral bus. An ID FIFO remembers
// which master issued each outstanding read so in-order responses route back.
module bus_arb2 #(
    parameter int RD_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_bus_req,
    input  logic        m0_bus_we,
    input  logic [31:0] m0_bus_addr,
    input  logic [3:0]  m0_bus_be,
    input  logic [31:0] m0_bus_wdata,
    output logic        m0_bus_ack,
    output logic        m0_bus_resp,
    output logic [31:0] m0_bus_rdata,

    input  logic        m1_bus_req,
    input  logic        m1_bus_we,
    input  logic [31:0] m1_bus_addr,
    input  logic [3:0]  m1_bus_be,
    input  logic [31:0] m1_bus_wdata,
    output logic        m1_bus_ack,
    output logic        m1_bus_resp,
    output logic [31:0] m1_bus_rdata,

    output logic        s_bus_req,
    output logic        s_bus_we,
    output logic [31:0] s_bus_addr,
    output logic [3:0]  s_bus_be,
    output logic [31:0] s_bus_wdata,
    input  logic        s_bus_ack,
    input  logic        s_bus_resp,
    input  logic [31:0] s_bus_rdata,

    output logic        orphan_resp_o
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(RD_DEPTH);

    logic [PW:0]   count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          id_mem [RD_DEPTH];
    logic          last_grant;

    logic fifo_full;
    logic fifo_empty;
    logic elig0;
    logic elig1;
    logic grant_valid;
    logic grant_id;
    logic push;
    logic pop;
    logic head_id;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // A full ID FIFO only holds back reads; writes always stay eligible.
    assign elig0 = m0_bus_req && (m0_bus_we || !fifo_full);
    assign elig1 = m1_bus_req && (m1_bus_we || !fifo_full);

    assign grant_valid = elig0 || elig1;
    assign grant_id    = (elig0 && elig1) ? ~last_grant : elig1;

    always_comb begin
        s_bus_req   = grant_valid;
        s_bus_we    = 1'b0;
        s_bus_addr  = '0;
        s_bus_be    = '0;
        s_bus_wdata = '0;
        if (grant_valid) begin
            if (grant_id) begin
                s_bus_we    = m1_bus_we;
                s_bus_addr  = m1_bus_addr;
                s_bus_be    = m1_bus_be;
                s_bus_wdata = m1_bus_wdata;
            end else begin
                s_bus_we    = m0_bus_we;
                s_bus_addr  = m0_bus_addr;
                s_bus_be    = m0_bus_be;
                s_bus_wdata = m0_bus_wdata;
            end
        end
    end

    assign m0_bus_ack = s_bus_ack && s_bus_req && !grant_id;
    assign m1_bus_ack = s_bus_ack && s_bus_req &&  grant_id;

    assign push    = s_bus_req && s_bus_ack && !s_bus_we;
    assign pop     = s_bus_resp && !fifo_empty && rst_i;
    assign head_id = id_mem[rd_ptr];

    // While reset is held every response is treated as an orphan.
    assign m0_bus_resp   = pop && !head_id;
    assign m1_bus_resp   = pop &&  head_id;
    assign orphan_resp_o = s_bus_resp && (fifo_empty || !rst_i);

    assign m0_bus_rdata = s_bus_rdata;
    assign m1_bus_rdata = s_bus_rdata;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= 1'b1;
        end else begin
            if (s_bus_req && s_bus_ack)
                last_grant <= grant_id;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset; the pointers decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (rst_i && push)
            id_mem[wr_ptr] <= grant_id;
    end

endmodule

// File: doc/bus_arb2.md
# bus_arb2

Two-master, one-slave arbiter for the SoC peripheral bus (req/we/addr/be/wdata/ack/resp/rdata). It sits between two bus masters (CPU data port and a debug/DMA master) and a single slave segment (GPIO, timers, UART decode). It grants the slave round-robin and tracks outstanding reads in an ID FIFO so each read response returns to the master that issued it. Multiple reads may be in flight.

## Interface
- RD_DEPTH, 4: max outstanding reads tracked; power of two, ≥2.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- m0_bus_req / m1_bus_req  in  1  master request; held until ack.
- m0_bus_we / m1_bus_we  in  1  1 = write, 0 = read.
- m0_bus_addr / m1_bus_addr  in  32  address.
- m0_bus_be / m1_bus_be  in  4  byte enables.
- m0_bus_wdata / m1_bus_wdata  in  32  write data.
- m0_bus_ack / m1_bus_ack  out  1  request accepted this cycle.
- m0_bus_resp / m1_bus_resp  out  1  read data valid this cycle.
- m0_bus_rdata / m1_bus_rdata  out  32  read data.
- s_bus_req  out  1  request to slave.
- s_bus_we, s_bus_addr, s_bus_be, s_bus_wdata  out  1/32/4/32  muxed from granted master.
- s_bus_ack  in  1  slave accepts request.
- s_bus_resp  in  1  slave read response valid.
- s_bus_rdata  in  32  slave read data.
- orphan_resp_o  out  1  pulse: s_bus_resp arrived with no read outstanding.

## Operation
- Grant (combinational): eligible(m) = m_req && !(m_we==0 && fifo_full). One eligible -> grant it. Both eligible -> grant master != last_grant. None -> no grant.
- s_bus_req = granted; s_bus_we/addr/be/wdata = granted master's fields, all-zero when no grant.
- mX_bus_ack = s_bus_ack && s_bus_req && grant==X; the other master's ack is 0.
- Accepted transfer (s_bus_req && s_bus_ack): last_grant <= granted master. If read, push master ID (1 bit) into ID FIFO.
- ID FIFO: RD_DEPTH entries; count 0..RD_DEPTH; full when count==RD_DEPTH. Pointers wrap modulo RD_DEPTH.
- Response: s_bus_resp && count>0 -> pop head. mHead_bus_resp = 1, other master's resp = 0.
- mX_bus_rdata = s_bus_rdata for both masters, unqualified; only resp qualifies it.
- s_bus_resp && count==0 -> orphan_resp_o = 1 that cycle; both mX_bus_resp = 0; FIFO unchanged.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Allowed when full: reads are not granted when full, so no push occurs then.
- A full FIFO blocks only reads. Writes continue to be granted, including to the master whose read is blocked.
- Reset (rst_i==0): count, pointers <= 0; last_grant <= 1, so master 0 wins the first tie.
- Reset mid-operation flushes the FIFO. Responses arriving after reset are orphans.

## Timing
- Request path fully combinational: mX_req -> s_bus_req -> s_bus_ack -> mX_ack, zero added latency.
- Response path combinational: s_bus_resp/s_bus_rdata -> mX_bus_resp/rdata same cycle.
- Arbitration and FIFO state registered; a push is visible in count the next cycle.
- A same-cycle response can return to a read accepted the same cycle only through the FIFO. The slave must respond no earlier than the cycle after ack.
- Output values during reset: all acks/resps 0 unless the slave drives ack/resp. s_bus_req follows the masters' req combinationally. orphan_resp_o = s_bus_resp.
- Slave responses return in request order; the arbiter relies on this.

## Test plan
- Single master read: m0 read addr 0x10, slave acks same cycle, responds next cycle with 0xA5 -> m0_ack=1 in request cycle, m0_resp=1 and rdata=0xA5 one cycle later, m1 sees nothing.
- Fairness: both masters hold write requests continuously with slave always acking -> grants alternate m0,m1,m0,m1… starting with m0 after reset.
- Out-of-flight routing: issue reads m0,m1,m1,m0 back-to-back, slave responds 3 cycles later in order with 1,2,3,4 -> resp routed m0(1), m1(2), m1(3), m0(4).
- FIFO full: RD_DEPTH=4, four reads accepted with no responses; a fifth read from m0 -> not granted. A concurrent m1 write -> granted. After one response, the m0 read is granted next cycle.
- Simultaneous push/pop at count=4: one response and one new read in the same cycle is impossible, since full blocks the read. At count=3, response + new read in one cycle -> count stays 3, routing order preserved.
- Orphan and reset: s_bus_resp with empty FIFO -> orphan_resp_o=1, no master resp. Reset (rst_i=0) with 2 reads outstanding, then a response -> orphan_resp_o=1 and count=0.
